skew_collector: RTL and testbench

//  Receiving end of the diagonal-skew lane protocol that feeds the systolic array.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/skew_collector_if.sv | 27 ++
 rtl/skew_slot_decode.sv | 27 ++
 rtl/skew_collector.sv | 140 ++++++++++++++
 tb/tb_skew_collector.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic-array datapath: default element width
// and array dimension, the element type, the de-skew FSM state encoding and
// the diagonal-skew window length helper.
package matmul_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N      = 3;

  typedef logic signed [DEF_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } skew_state_e;

  // Number of cycles a skewed frame of n lanes occupies on the lanes.
  function automatic int win_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_collector_if.sv
// Lane-side and matrix-side signals of the skew collector. The slave modport
// is the collector itself; the master modport is whoever drives the skewed
// lanes and consumes the assembled matrix.
interface skew_collector_if #(
  parameter int DATA_W = matmul_pkg::DEF_DATA_W,
  parameter int N      = matmul_pkg::DEF_N
);

  logic                     start;
  logic                     col_mode;
  logic signed [DATA_W-1:0] lane_in [N];
  logic signed [DATA_W-1:0] mat_out [N][N];
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output start, col_mode, lane_in, out_ready,
    input  mat_out, out_valid, busy
  );

  modport slave (
    input  start, col_mode, lane_in, out_ready,
    output mat_out, out_valid, busy
  );

endinterface

// File: rtl/skew_slot_decode.sv
// Per-lane slot decoder: for window cycle cnt, lane LANE owns a slot when
// 0 <= cnt-LANE < N; the element index within the lane is cnt-LANE.
module skew_slot_decode #(
  parameter int N    = 3,
  parameter int CW   = 3,
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic [CW-1:0] cnt,
  output logic          we,
  output logic [IW-1:0] idx
);

  int diff;

  // Decode the lane's slot position relative to the current window cycle
  always_comb begin
    diff = int'(cnt) - LANE;
    we   = 1'b0;
    idx  = '0;
    if (diff >= 0 && diff < N) begin
      we  = 1'b1;
      idx = diff[IW-1:0];
    end
  end

endmodule

// File: rtl/skew_collector.sv
// Diagonal-skew lane collector: de-skews N staggered lanes into an NxN matrix
// and presents it on a valid/ready output.
// Optional feature macro: DESKEW_OVERRUN_EN adds a sticky overrun flag that
// records any start pulse the collector had to ignore.
module skew_collector
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N
) (
  input  logic             clk,
  input  logic             rst,
  skew_collector_if.slave  bus
`ifdef DESKEW_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int CW   = $clog2(2 * N);
  localparam int IW   = $clog2(N);
  localparam int LAST = win_len(N) - 1;

  skew_state_e              state;
  logic [CW-1:0]            cnt;
  logic                     col_q;
  logic                     valid_q;
  logic                     busy_q;
  logic signed [DATA_W-1:0] mat [N][N];

  logic                     handshake;
  logic                     accept;
  logic                     cap_en;
  logic                     mode;
  logic [CW-1:0]            cslot;
  logic                     we  [N];
  logic [IW-1:0]            idx [N];

  // A new frame's slot 0 is captured in the very cycle start is accepted,
  // either from IDLE or on the HOLD handshake cycle.
  assign handshake = (state == HOLD) && bus.out_ready;
  assign accept    = bus.start && ((state == IDLE) || handshake);
  assign cap_en    = (state == CAPTURE) || accept;
  assign cslot     = (state == CAPTURE) ? cnt : '0;
  assign mode      = (state == CAPTURE) ? col_q : bus.col_mode;

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_slot_decode #(
      .N    (N),
      .CW   (CW),
      .IW   (IW),
      .LANE (g)
    ) u_dec (
      .cnt (cslot),
      .we  (we[g]),
      .idx (idx[g])
    );
  end

  // Frame sequencing: window counter, latched orientation, valid and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      col_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CAPTURE;
            cnt    <= CW'(1);
            col_q  <= bus.col_mode;
            busy_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == CW'(LAST)) begin
            state   <= HOLD;
            cnt     <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (bus.start) begin
              state  <= CAPTURE;
              cnt    <= CW'(1);
              col_q  <= bus.col_mode;
              busy_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Matrix working register: each lane writes its owned slot for this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mat <= '{default: '0};
    end else if (cap_en) begin
      for (int k = 0; k < N; k++) begin
        if (we[k]) begin
          if (mode) mat[idx[k]][k] <= bus.lane_in[k];
          else      mat[k][idx[k]] <= bus.lane_in[k];
        end
      end
    end
  end

`ifdef DESKEW_OVERRUN_EN
  logic ignored;
  logic overrun_q;

  assign ignored = bus.start &&
                   ((state == CAPTURE) || ((state == HOLD) && !bus.out_ready));

  // Sticky record of any start pulse that could not be honoured
  always_ff @(posedge clk) begin
    if (rst)          overrun_q <= 1'b0;
    else if (ignored) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

  assign bus.mat_out   = mat;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_skew_collector.sv
// Scoreboard bench for skew_collector (N=3, DATA_W=16). Lane data is
// generated from the active frame's matrix using the diagonal skew; every
// other lane cycle carries 16'sh7FFF.
module tb_skew_collector;
  import matmul_pkg::*;

  typedef logic signed [15:0] mat_t [3][3];
  typedef struct {
    mat_t m;
    int   hs;
  } exp_t;

  localparam logic signed [15:0] GARB = 16'sh7FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t q[$];
  mat_t cur_a;
  int   cur_t = -100;

  skew_collector_if #(.DATA_W(16), .N(3)) bus ();

`ifdef DESKEW_OVERRUN_EN
  logic overrun;
  skew_collector #(.DATA_W(16), .N(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .overrun (overrun)
  );
`else
  skew_collector #(.DATA_W(16), .N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_mat(input string name, input mat_t want);
    int bad = 0;
    int br = 0;
    int bc = 0;
    vectors++;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (bus.mat_out[r][c] !== want[r][c]) begin
          if (bad == 0) begin br = r; bc = c; end
          bad++;
        end
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s: mat_out[%0d][%0d] got %0d, want %0d (%0d bad cells, cycle %0d)",
               name, br, bc, bus.mat_out[br][bc], want[br][bc], bad, cyc);
    end
  endtask

  // Drive the skewed lanes for the current cycle, then advance one clock
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      int j;
      j = cyc - cur_t - k;
      bus.lane_in[k] = (j >= 0 && j < 3) ? cur_a[k][j] : GARB;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic begin_frame(input mat_t a, input logic cm, input mat_t expm, input int hs_off);
    exp_t e;
    cur_a = a;
    cur_t = cyc;
    bus.start = 1'b1;
    bus.col_mode = cm;
    e.m = expm;
    e.hs = cyc + hs_off;
    q.push_back(e);
    tick();
  endtask

  // Monitor: every accepted frame is matched against the scoreboard head
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got frame at cycle %0d, want none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("frame_cycle", cyc, mon_e.hs);
        chk_mat("frame_data", mon_e.m);
      end
    end
  end

  mat_t A1 = '{'{16'sd1, 16'sd2, 16'sd3}, '{16'sd4, 16'sd5, 16'sd6}, '{16'sd7, 16'sd8, 16'sd9}};
  mat_t A1T = '{'{16'sd1, 16'sd4, 16'sd7}, '{16'sd2, 16'sd5, 16'sd8}, '{16'sd3, 16'sd6, 16'sd9}};
  mat_t A3 = '{'{16'sd10, -16'sd32768, 16'sd30}, '{-16'sd1, 16'sd0, 16'sd7}, '{16'sd100, 16'sd200, 16'sd300}};
  mat_t A2 = '{'{-16'sd5, 16'sd11, 16'sd12}, '{16'sd13, -16'sd14, 16'sd15}, '{16'sd16, 16'sd17, -16'sd18}};
  mat_t A2T = '{'{-16'sd5, 16'sd13, 16'sd16}, '{16'sd11, -16'sd14, 16'sd17}, '{16'sd12, 16'sd15, -16'sd18}};
  mat_t Z = '{default: 16'sd0};

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.col_mode = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) bus.lane_in[k] = GARB;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk_mat("reset_mat", Z);
`ifdef DESKEW_OVERRUN_EN
    chk("reset_overrun", int'(overrun), 0);
`endif
    rst = 1'b0;
    repeat (2) tick();

    // Basic row mode
    begin_frame(A1, 1'b0, A1, 5);
    chk("basic_busy", int'(bus.busy), 1);
    repeat (5) tick();
    chk("basic_valid_drop", int'(bus.out_valid), 0);
    chk("basic_busy_idle", int'(bus.busy), 0);
    repeat (2) tick();

    // Column mode gives the transpose
    begin_frame(A1, 1'b1, A1T, 5);
    repeat (7) tick();

    // Garbage outside slots, most-negative value inside one slot
    begin_frame(A3, 1'b0, A3, 5);
    repeat (7) tick();

    // Backpressure with an ignored start while holding
    bus.out_ready = 1'b0;
    t0 = cyc;
    begin_frame(A2, 1'b0, A2, 15);
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", int'(bus.out_valid), 1);
      chk_mat("bp_stable", A2);
      chk("bp_busy", int'(bus.busy), 0);
      if (cyc == t0 + 8) bus.start = 1'b1;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", int'(bus.out_valid), 0);
`ifdef DESKEW_OVERRUN_EN
    chk("bp_overrun", int'(overrun), 1);
`endif
    repeat (2) tick();

    // Back-to-back: second start lands on the handshake cycle
    begin_frame(A1, 1'b0, A1, 5);
    repeat (4) tick();
    chk("b2b_valid_first", int'(bus.out_valid), 1);
    begin_frame(A2, 1'b1, A2T, 5);
    chk("b2b_busy", int'(bus.busy), 1);
    repeat (5) tick();
    chk("b2b_valid_drop", int'(bus.out_valid), 0);
    repeat (2) tick();

    // Reset in the middle of a capture discards the frame
    cur_a = A3;
    cur_t = cyc;
    bus.start = 1'b1;
    bus.col_mode = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk_mat("midrst_mat", Z);
`ifdef DESKEW_OVERRUN_EN
    chk("midrst_overrun", int'(overrun), 0);
`endif
    repeat (8) tick();
    begin_frame(A2, 1'b0, A2, 5);
    repeat (7) tick();

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
